// File: rtl/lfsr_galois_gen.sv
// Parametrised Galois LFSR with step enable, seed load, period measurement and lockup flag.
// Optional macro LFSR_LOCKUP_RECOVER_EN: a zero seed loads SEED instead, and lockup is tied low.
module lfsr_galois_gen #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b00101,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;

  // One Galois step: shift left, fold the MSB back through the tap mask.
  always_comb begin
    nxt = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q_q[WIDTH-1]}} & TAPS);
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  always_comb begin
    load_val = (seed == '0) ? SEED : seed;
  end
`else
  always_comb begin
    load_val = seed;
  end
`endif

  // Load beats enable; the period counter restarts whenever q returns to start.
  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (load) begin
      q_d     = load_val;
      start_d = load_val;
      cnt_d   = '0;
    end else if (en) begin
      q_d = nxt;
      if (nxt == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + WIDTH'(1);
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q_q      <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign q       = q_q;
  assign bit_out = q_q[WIDTH-1];
  assign wrap    = wrap_q;
  assign period  = period_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
  assign lockup = 1'b0;
`else
  assign lockup = (q_q == '0);
`endif

endmodule

// File: tb/tb_lfsr_galois_gen.sv
// Bench for lfsr_galois_gen: polynomial-arithmetic reference model checked every cycle, plus literal pins.
module tb_lfsr_galois_gen;

  localparam int unsigned W    = 5;
  localparam logic [W-1:0] TP  = 5'b00101;
  localparam logic [W-1:0] SD  = 5'b11111;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] q, period;
  logic         bit_out, wrap, lockup;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  lfsr_galois_gen #(.WIDTH(W), .TAPS(TP), .SEED(SD)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .load(load), .seed(seed),
    .q(q), .bit_out(bit_out), .wrap(wrap), .period(period), .lockup(lockup)
  );

  always #5 clk = ~clk;

  // Reference: multiply the state polynomial by x modulo x^W + taps.
  function automatic logic [W-1:0] mul_x(input logic [W-1:0] v);
    longint unsigned m;
    longint unsigned poly;
    poly = (longint'(1) << W) | longint'(TP);
    m = longint'(v) << 1;
    if (((m >> W) & 1) != 0) m = m ^ poly;
    return W'(m);
  endfunction

  logic [W-1:0] m_q, m_start, m_period;
  int           m_steps;
  bit           m_wrap;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q = SD; m_start = SD; m_steps = 0; m_period = '0; m_wrap = 1'b0;
    end else if (load) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
      m_q = (seed == 0) ? SD : seed;
`else
      m_q = seed;
`endif
      m_start = m_q; m_steps = 0; m_wrap = 1'b0;
    end else if (en) begin
      m_q = mul_x(m_q);
      m_steps++;
      m_wrap = (m_q == m_start);
      if (m_wrap) begin
        m_period = W'(m_steps);
        m_steps = 0;
      end
    end else begin
      m_wrap = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_q", 32'(q), 32'(m_q));
      check("model_bit_out", 32'(bit_out), 32'(m_q[W-1]));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_period", 32'(period), 32'(m_period));
`ifdef LFSR_LOCKUP_RECOVER_EN
      check("model_lockup", 32'(lockup), 32'd0);
`else
      check("model_lockup", 32'(lockup), 32'(m_q == 0));
`endif
    end
  end

  // Apply inputs for one cycle; returns 2 time units after the edge that consumed them.
  task automatic cyc(input logic e, input logic l, input logic [W-1:0] s);
    en = e; load = l; seed = s;
    @(posedge clk); #2;
  endtask

  task automatic async_reset();
    #1 rst_b = 1'b0;
    #1;
    check("rst_q", 32'(q), 32'h1f);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    rst_b = 1'b1;
  endtask

  initial begin
    int nw;
    logic [W-1:0] exp1 [4];
    logic [W-1:0] exp4 [5];
    exp1[0] = 5'b11011; exp1[1] = 5'b10011; exp1[2] = 5'b00011; exp1[3] = 5'b00110;
    exp4[0] = 5'b00010; exp4[1] = 5'b00100; exp4[2] = 5'b01000; exp4[3] = 5'b10000; exp4[4] = 5'b00101;

    #12 rst_b = 1'b1;
    cmp_on = 1'b1;
    check("reset_q", 32'(q), 32'h1f);
    check("reset_lockup", 32'(lockup), 32'd0);
    check("reset_period", 32'(period), 32'd0);

    // Opening sequence from reset.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("seq_q", 32'(q), 32'(exp1[i]));
    end

    // Full period from reset.
    @(posedge clk); #2;
    async_reset();
    for (int i = 0; i < 31; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("free_wrap", 32'(wrap), 32'(i == 30));
    end
    check("free_q", 32'(q), 32'h1f);
    check("free_period", 32'(period), 32'd31);
    for (int i = 0; i < 31; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("free2_wrap", 32'(wrap), 32'(i == 30));
    end

    // Async reset mid-run with q != SEED.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
    async_reset();
    cyc(1'b1, 1'b0, '0);
    check("after_rst_q", 32'(q), 32'h1b);

    // Alternating enable.
    async_reset();
    nw = 0;
    for (int i = 0; i < 62; i++) begin
      cyc((i % 2) == 0, 1'b0, '0);
      if (wrap) nw++;
    end
    check("alt_wraps", 32'(nw), 32'd1);
    check("alt_period", 32'(period), 32'd31);

    // Load beats enable.
    cyc(1'b1, 1'b1, 5'b00001);
    check("load_q", 32'(q), 32'h01);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("load_seq_q", 32'(q), 32'(exp4[i]));
    end

    // Consecutive loads: last one wins.
    cyc(1'b0, 1'b1, 5'b01010);
    cyc(1'b1, 1'b1, 5'b00111);
    check("dload_q", 32'(q), 32'h07);

    // Zero seed.
    cyc(1'b0, 1'b1, '0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("zero_q", 32'(q), 32'h1f);
    check("zero_lockup", 32'(lockup), 32'd0);
`else
    check("zero_q", 32'(q), 32'd0);
    check("zero_lockup", 32'(lockup), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      check("zero_step_q", 32'(q), 32'd0);
      check("zero_wrap", 32'(wrap), 32'd1);
      check("zero_period", 32'(period), 32'd1);
    end
`endif

    // Randomised traffic.
    cyc(1'b0, 1'b1, 5'b10110);
    for (int i = 0; i < 600; i++) begin
      logic l;
      logic [W-1:0] s;
      l = ($urandom_range(0, 39) == 0);
      s = W'($urandom);
      if ($urandom_range(0, 7) == 0) s = '0;
      cyc($urandom_range(0, 3) != 0, l, s);
      if (i == 300) async_reset();
    end

    cyc(1'b0, 1'b0, '0);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_galois_gen.md
Name: lfsr_galois_gen

Overview:
- Parametrised Galois LFSR; successor to the fixed 5-bit, reset-to-ones LFSR.
- Adds generic width and polynomial, step enable, and runtime seed load.
- Adds a period measurement counter with a wrap pulse, plus all-zero lockup detection.
- Used as a pseudo-random source and self-checking sequence generator in lab datapaths and benches.

Parameters:
- WIDTH, 5, register width; legal range 3..32.
- TAPS, 5'b00101, feedback mask (WIDTH bits); bit i set means bit i receives the MSB XOR. Bit 0 must be 1. Default implements x^5+x^2+1.
- SEED, all ones ({WIDTH{1'b1}}), reset value of q; must be nonzero.

Ports:
- clk  in  1  clock; rising edge active
- rst_b  in  1  asynchronous active-low reset
- en  in  1  advance one step this cycle
- load  in  1  load seed this cycle; has priority over en
- seed  in  WIDTH  value loaded when load=1
- q  out  WIDTH  current LFSR state (registered)
- bit_out  out  1  equals q[WIDTH-1] (combinational from q)
- wrap  out  1  one-cycle registered pulse; high in the cycle q returns to the start value
- period  out  WIDTH  last measured period in steps; 0 until the first wrap
- lockup  out  1  high while q == 0 (combinational from q)

Behaviour:
- Clock and reset: one clock, clk; reset rst_b is asynchronous, active-low.
- Reset values: q=SEED, start=SEED, cnt=0, period=0, wrap=0.
- Internal state:
  - start register (WIDTH bits): the value q began from.
  - cnt register (WIDTH bits): steps taken since start.
- Step function: nxt = {q[WIDTH-2:0],1'b0} ^ ({WIDTH{q[WIDTH-1]}} & TAPS).
- Per rising edge, priority order:
  1. load=1:
     - q<=seed; start<=seed; cnt<=0; wrap<=0; period unchanged.
     - en is ignored this cycle.
  2. en=1, load=0:
     - q<=nxt.
     - If nxt==start: wrap<=1, period<=cnt+1, cnt<=0.
     - Otherwise: wrap<=0, cnt<=cnt+1.
  3. Neither: q, cnt, start and period hold; wrap<=0.
- Latency:
  - q changes one cycle after en/load is sampled.
  - wrap is asserted in the same cycle q shows the start value again.
- Period bound:
  - TAPS[0]=1 makes the step a bijection, so q always returns to start within 2^WIDTH-1 steps.
  - cnt+1 therefore fits in WIDTH bits; no saturation logic is required.
- Maximal-length polynomial: period = 2^WIDTH-1 (31 for defaults).
- All-zero state: fixed point of the step. If q==0 and en=1:
  - nxt==start==0, so wrap pulses every enabled cycle and period=1.
  - lockup stays high.
- Reset mid-sequence: asynchronous; all registers return to reset values immediately, and wrap drops without waiting for a clock.
- load and en asserted together: load wins; no step is taken.
- Consecutive load cycles: the last seed wins; cnt stays 0.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - load with seed==0 loads SEED into both q and start, instead of zero.
  - lockup therefore can never assert (it is tied low).
- Undefined:
  - zero is loaded verbatim.
  - all-zero behaviour is exactly as stated under Behaviour.

Test Plan:
1. Reset with defaults, hold en=1 → q after reset = 5'b11111; then 11011, 10011, 00011, 00110 on successive edges; lockup=0.
2. Free-run 31 enabled steps from reset → wrap pulses exactly once, on step 31, with q=11111 and period=5'd31. The next wrap follows 31 steps later.
3. Toggle en 1/0 alternately for 62 cycles → q advances only on en=1 cycles. wrap occurs after 31 enabled steps; period=31.
4. load=1, en=1, seed=5'b00001 in the same cycle → next q=00001 with no step; then enabled steps give 00010, 00100, 01000, 10000, 00101.
5. Undefined macro: load seed=0, then en=1 → q stays 0, lockup=1, wrap=1 every cycle, period=1. Defined macro: q=11111, lockup=0.
6. Assert rst_b=0 mid-run, between clock edges, with q≠SEED → q=11111, wrap=0 and period=0 immediately, before the next edge. The sequence restarts correctly after release.
